// File: rtl/control_sequencer_pkg.sv
// Shared definitions for the softcore micro-sequencer: opcodes, step encodings
// and control-word bit positions used by the sequencer, datapath and bench.
package control_sequencer_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    T0 = 3'd0,
    T1 = 3'd1,
    T2 = 3'd2,
    T3 = 3'd3,
    T4 = 3'd4
  } step_t;

  // Bus drivers occupy the low bits so the one-driver mask stays contiguous.
  localparam int CW_PC_OUT   = 0;
  localparam int CW_IR_OUT   = 1;
  localparam int CW_RAM_OUT  = 2;
  localparam int CW_A_OUT    = 3;
  localparam int CW_ALU_OUT  = 4;
  localparam int CW_PC_INC   = 5;
  localparam int CW_PC_IN    = 6;
  localparam int CW_MAR_IN   = 7;
  localparam int CW_RAM_IN   = 8;
  localparam int CW_IR_IN    = 9;
  localparam int CW_A_IN     = 10;
  localparam int CW_B_IN     = 11;
  localparam int CW_OUT_IN   = 12;
  localparam int CW_FLAGS_IN = 13;
  localparam int CW_ALU_SUB  = 14;
  localparam int CW_HLT      = 15;
  localparam int CW_W        = 16;

  typedef logic [CW_W-1:0] ctrl_word_t;

  localparam ctrl_word_t BUS_DRV_MASK = ctrl_word_t'(16'h001F);

  function automatic step_t step_after(input step_t s);
    case (s)
      T0:      return T1;
      T1:      return T2;
      T2:      return T3;
      T3:      return T4;
      default: return T0;
    endcase
  endfunction

endpackage

// File: rtl/control_sequencer_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word and a flag
// marking the final step of the instruction.
module control_sequencer_rom
  import control_sequencer_pkg::*;
(
  input  logic [3:0]  opcode,
  input  step_t       step,
  input  logic        flag_c,
  input  logic        flag_z,
  output ctrl_word_t  cw,
  output logic        last_step
);

  always_comb begin
    cw        = '0;
    last_step = 1'b0;
    case (step)
      T0: begin
        cw[CW_PC_OUT] = 1'b1;
        cw[CW_MAR_IN] = 1'b1;
      end
      T1: begin
        cw[CW_RAM_OUT] = 1'b1;
        cw[CW_IR_IN]   = 1'b1;
        cw[CW_PC_INC]  = 1'b1;
      end
      T2: begin
        case (opcode)
          OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_MAR_IN] = 1'b1;
          end
          OP_LDI: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_A_IN]   = 1'b1;
            last_step     = 1'b1;
          end
          OP_JMP: begin
            cw[CW_IR_OUT] = 1'b1;
            cw[CW_PC_IN]  = 1'b1;
            last_step     = 1'b1;
          end
          OP_JC: begin
            cw[CW_IR_OUT] = flag_c;
            cw[CW_PC_IN]  = flag_c;
            last_step     = 1'b1;
          end
          OP_JZ: begin
            cw[CW_IR_OUT] = flag_z;
            cw[CW_PC_IN]  = flag_z;
            last_step     = 1'b1;
          end
          OP_OUT: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_OUT_IN] = 1'b1;
            last_step     = 1'b1;
          end
          OP_HLT: begin
            cw[CW_HLT] = 1'b1;
            last_step  = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T3: begin
        case (opcode)
          OP_LDA: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_A_IN]    = 1'b1;
            last_step      = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            cw[CW_RAM_OUT] = 1'b1;
            cw[CW_B_IN]    = 1'b1;
          end
          OP_STA: begin
            cw[CW_A_OUT]  = 1'b1;
            cw[CW_RAM_IN] = 1'b1;
            last_step     = 1'b1;
          end
          default: last_step = 1'b1;
        endcase
      end
      T4: begin
        // Only ADD/SUB reach T4; anything else just falls back to fetch.
        if (opcode == OP_ADD || opcode == OP_SUB) begin
          cw[CW_ALU_OUT]  = 1'b1;
          cw[CW_A_IN]     = 1'b1;
          cw[CW_FLAGS_IN] = 1'b1;
          cw[CW_ALU_SUB]  = (opcode == OP_SUB);
        end
        last_step = 1'b1;
      end
      default: last_step = 1'b1;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Micro-step counter, sticky halt and run gating for the softcore bus
// datapath; decode lives in control_sequencer_rom.
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int BIT_COUNT = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run_en,
  input  logic [BIT_COUNT-1:0] ir_val,
  input  logic                 flag_c,
  input  logic                 flag_z,
  output logic                 pc_out,
  output logic                 ir_out,
  output logic                 ram_out,
  output logic                 a_out,
  output logic                 alu_out,
  output logic                 pc_inc,
  output logic                 pc_in,
  output logic                 mar_in,
  output logic                 ram_in,
  output logic                 ir_in,
  output logic                 a_in,
  output logic                 b_in,
  output logic                 out_in,
  output logic                 flags_in,
  output logic                 alu_sub,
  output logic                 halted,
  output logic [2:0]           t_state
);

  // state   | meaning
  // T0      | fetch: PC -> MAR
  // T1      | fetch: RAM -> IR, PC++
  // T2..T4  | execute, decoded from ir_val opcode
  // halted  | sticky; counter parked at T0 until rst

  step_t      step_q, step_d;
  logic       halted_q, halted_d;
  ctrl_word_t rom_cw, cw;
  logic       rom_last;
  logic       active;
  logic       unused_ir;

  assign unused_ir = ^ir_val[BIT_COUNT-5:0];

  control_sequencer_rom u_rom (
    .opcode    (ir_val[BIT_COUNT-1 -: 4]),
    .step      (step_q),
    .flag_c    (flag_c),
    .flag_z    (flag_z),
    .cw        (rom_cw),
    .last_step (rom_last)
  );

  assign active = run_en & ~halted_q & ~rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      step_q   <= T0;
      halted_q <= 1'b0;
    end else begin
      step_q   <= step_d;
      halted_q <= halted_d;
    end
  end

  always_comb begin
    step_d   = step_q;
    halted_d = halted_q;
    if (active) begin
      step_d = rom_last ? T0 : step_after(step_q);
      if (rom_cw[CW_HLT]) halted_d = 1'b1;
    end
  end

  assign cw = active ? rom_cw : '0;

  assign pc_out   = cw[CW_PC_OUT];
  assign ir_out   = cw[CW_IR_OUT];
  assign ram_out  = cw[CW_RAM_OUT];
  assign a_out    = cw[CW_A_OUT];
  assign alu_out  = cw[CW_ALU_OUT];
  assign pc_inc   = cw[CW_PC_INC];
  assign pc_in    = cw[CW_PC_IN];
  assign mar_in   = cw[CW_MAR_IN];
  assign ram_in   = cw[CW_RAM_IN];
  assign ir_in    = cw[CW_IR_IN];
  assign a_in     = cw[CW_A_IN];
  assign b_in     = cw[CW_B_IN];
  assign out_in   = cw[CW_OUT_IN];
  assign flags_in = cw[CW_FLAGS_IN];
  assign alu_sub  = cw[CW_ALU_SUB];
  assign halted   = halted_q;
  assign t_state  = step_q;

  a_one_bus_driver : assert property (@(posedge clk) $countones(cw & BUS_DRV_MASK) <= 1);

endmodule
